fifo_rd_arbiter: RTL and testbench

Read-side burst arbiter for the asynchronous FIFO, in the rd_clk domain. It shares the single FIFO read port among NUM_REQ consumers. Each consumer requests a burst of a given length; the arbiter grants one consumer at a time in round-robin order and drives the FIFO read enable. It returns each popped word to the granted consumer through a registered valid/ready output stage.

---
 rtl/fifo_rd_arbiter_if.sv | 29 ++
 rtl/fifo_rd_arbiter.sv | 129 ++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_arbiter_if.sv
// rtl/fifo_rd_arbiter_if.sv - consumer request/response and FIFO read-port bundle for fifo_rd_arbiter
interface fifo_rd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic                     rd_empty;
  logic [DATA_W-1:0]        rd_data;
  logic                     rd_en;
  logic [NUM_REQ-1:0]       gnt;
  logic                     busy;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_last;
  logic [NUM_REQ-1:0]       out_ready;
  logic                     done;

  modport master (
    input  req, req_len, rd_empty, rd_data, out_ready,
    output rd_en, gnt, busy, out_data, out_valid, out_last, done
  );

  modport slave (
    output req, req_len, rd_empty, rd_data, out_ready,
    input  rd_en, gnt, busy, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/fifo_rd_arbiter.sv
// rtl/fifo_rd_arbiter.sv - round-robin burst arbiter sharing one FIFO read port among NUM_REQ consumers
module fifo_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_rstn,
  fifo_rd_arbiter_if.master    bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     rr_ptr, sel, pick_idx;
  logic                 pick_found;
  logic [LEN_W-1:0]     rem, pick_len;
  logic [LEN_W-1:0]     len_arr [NUM_REQ];
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [DATA_W-1:0]    data_q;
  logic                 valid_q, last_q, done_q;
  logic                 pop, out_hs, sel_ready;
  int                   cand;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
    assign len_arr[i]  = bus.req_len[i*LEN_W +: LEN_W];
    assign eligible[i] = bus.req[i] & (len_arr[i] != '0);
  end

  // First eligible consumer at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_len   = '0;
    cand       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_found && eligible[PTR_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
        pick_len   = len_arr[PTR_W'(cand)];
      end
    end
  end

  assign sel_ready = bus.out_ready[sel];

  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    out_hs    = valid_q & sel_ready;
    case (state)
      IDLE: begin
        if (pick_found) state_nxt = XFER;
      end
      XFER: begin
        pop = !bus.rd_empty && (rem != '0) && (!valid_q || sel_ready);
        if (pop && rem == LEN_W'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A pop may coincide with acceptance of the previous word; the new word simply replaces it.
  always_ff @(posedge rd_clk or negedge rd_rstn) begin
    if (!rd_rstn) begin
      gnt_q   <= '0;
      sel     <= '0;
      rem     <= '0;
      rr_ptr  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt_q <= NUM_REQ'(1) << pick_idx;
            sel   <= pick_idx;
            rem   <= pick_len;
          end
        end
        XFER: begin
          if (pop) begin
            data_q  <= bus.rd_data;
            valid_q <= 1'b1;
            last_q  <= (rem == LEN_W'(1));
            rem     <= rem - LEN_W'(1);
          end else if (out_hs) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        DRAIN: begin
          if (out_hs) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            gnt_q   <= '0;
            done_q  <= 1'b1;
            rr_ptr  <= (sel == PTR_W'(NUM_REQ - 1)) ? '0 : sel + PTR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // busy covers the done cycle, during which the FSM is already back in IDLE.
  assign bus.busy      = (state != IDLE) | done_q;
  assign bus.rd_en     = pop;
  assign bus.gnt       = gnt_q;
  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// tb/tb_fifo_rd_arbiter.sv - scoreboard bench for fifo_rd_arbiter
module tb_fifo_rd_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int LEN_W   = 4;

  typedef struct packed {
    logic [1:0]        cons;
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;

  logic rd_clk = 1'b0;
  logic rd_rstn;
  always #5 rd_clk = ~rd_clk;

  fifo_rd_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  fifo_rd_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .rd_clk  (rd_clk),
    .rd_rstn (rd_rstn),
    .bus     (bus)
  );

  word_t              exp_q[$];
  logic [DATA_W-1:0]  fifo_q[$];
  logic [NUM_REQ-1:0] grant_log[$];
  int n_vec, n_err, n_pop, n_done;

  logic [NUM_REQ-1:0] s_gnt, prev_gnt;
  logic               s_busy, s_rd_en, s_valid, s_last, s_done, s_empty, s_ready_sel;
  logic [DATA_W-1:0]  s_data;

  task automatic update_fifo_pins();
    bus.rd_empty = (fifo_q.size() == 0);
    bus.rd_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic fill_fifo(input int n, input logic [DATA_W-1:0] base);
    for (int k = 0; k < n; k++) fifo_q.push_back(base + DATA_W'(k));
    update_fifo_pins();
  endtask

  task automatic expect_burst(input int cons, input int n, input logic [DATA_W-1:0] base);
    word_t w;
    for (int k = 0; k < n; k++) begin
      w.cons = 2'(cons);
      w.data = base + DATA_W'(k);
      w.last = (k == n - 1);
      exp_q.push_back(w);
    end
  endtask

  // One clock: sample mid-cycle, score accepted words, then model the FIFO pop after the edge.
  task automatic tick();
    word_t e;
    int    cons;
    @(negedge rd_clk);
    s_gnt       = bus.gnt;
    s_busy      = bus.busy;
    s_rd_en     = bus.rd_en;
    s_valid     = bus.out_valid;
    s_last      = bus.out_last;
    s_data      = bus.out_data;
    s_done      = bus.done;
    s_empty     = bus.rd_empty;
    s_ready_sel = |(bus.out_ready & bus.gnt);
    cons = 0;
    for (int i = 0; i < NUM_REQ; i++) if (s_gnt[i]) cons = i;
    if (s_gnt != '0 && prev_gnt == '0) grant_log.push_back(s_gnt);
    prev_gnt = s_gnt;
    if (s_rd_en) n_pop++;
    if (s_done) n_done++;
    if (s_valid && s_ready_sel) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got data=%0h cons=%0d, expected no word", s_data, cons);
      end else begin
        e = exp_q.pop_front();
        if (s_data !== e.data || s_last !== e.last || cons != int'(e.cons)) begin
          n_err++;
          $display("FAIL sb_word: got data=%0h last=%0b cons=%0d, expected data=%0h last=%0b cons=%0d",
                   s_data, s_last, cons, e.data, e.last, e.cons);
        end
      end
    end
    @(posedge rd_clk);
    #1;
    if (s_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
    update_fifo_pins();
  endtask

  task automatic clear_counts();
    n_pop = 0;
    n_done = 0;
    grant_log.delete();
  endtask

  task automatic test_reset();
    rd_rstn = 1'b0;
    bus.req = '0;
    bus.req_len = '0;
    bus.out_ready = '0;
    prev_gnt = '0;
    update_fifo_pins();
    repeat (2) tick();
    n_vec++;
    if ({s_gnt, s_busy, s_rd_en, s_valid, s_last, s_data, s_done} !== '0) begin
      n_err++;
      $display("FAIL reset_values: got gnt=%b busy=%b rd_en=%b valid=%b last=%b data=%0h done=%b, expected all 0",
               s_gnt, s_busy, s_rd_en, s_valid, s_last, s_data, s_done);
    end
    rd_rstn = 1'b1;
  endtask

  task automatic test_round_robin();
    for (int b = 0; b < 5; b++) expect_burst(b % 4, 2, 8'h10 + DATA_W'(2 * b));
    fill_fifo(10, 8'h10);
    clear_counts();
    bus.out_ready = 4'b1111;
    bus.req_len = {4{4'd2}};
    bus.req = 4'b1111;
    for (int c = 0; c < 200 && n_done < 5; c++) begin
      tick();
      if (grant_log.size() >= 5) bus.req = '0;
    end
    n_vec++;
    if (n_done != 5) begin n_err++; $display("FAIL rr_done_count: got %0d expected 5", n_done); end
    n_vec++;
    if (n_pop != 10) begin n_err++; $display("FAIL rr_pop_count: got %0d expected 10", n_pop); end
    for (int b = 0; b < 5; b++) begin
      n_vec++;
      if (b >= grant_log.size() || grant_log[b] !== NUM_REQ'(1 << (b % 4))) begin
        n_err++;
        $display("FAIL rr_order: grant %0d got %b expected %b", b,
                 (b < grant_log.size()) ? grant_log[b] : 4'b0, NUM_REQ'(1 << (b % 4)));
      end
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rr_leftover: got %0d words pending expected 0", exp_q.size()); end
  endtask

  task automatic test_single_burst();
    int cyc;
    fill_fifo(3, 8'h0A);
    expect_burst(0, 3, 8'h0A);
    clear_counts();
    bus.out_ready = 4'b0001;
    bus.req_len = 16'h0003;
    bus.req = 4'b0001;
    tick();
    n_vec++;
    if (s_gnt !== 4'b0000) begin n_err++; $display("FAIL sb_gnt_latency: got gnt=%b expected 0000", s_gnt); end
    tick();
    bus.req = '0;
    n_vec++;
    if (s_gnt !== 4'b0001 || s_busy !== 1'b1 || s_rd_en !== 1'b1) begin
      n_err++;
      $display("FAIL sb_grant_cycle: got gnt=%b busy=%b rd_en=%b expected 0001 1 1", s_gnt, s_busy, s_rd_en);
    end
    cyc = 0;
    while (!s_done && cyc < 50) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc != 4 || s_busy !== 1'b1) begin
      n_err++;
      $display("FAIL sb_grant_to_done: got %0d cycles busy=%b expected 4 busy=1", cyc, s_busy);
    end
    tick();
    n_vec++;
    if (s_done !== 1'b0 || s_busy !== 1'b0 || n_done != 1 || n_pop != 3) begin
      n_err++;
      $display("FAIL sb_after_done: got done=%b busy=%b dones=%0d pops=%0d expected 0 0 1 3",
               s_done, s_busy, n_done, n_pop);
    end
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d expected 0", exp_q.size()); end
  endtask

  task automatic test_empty_stall();
    fill_fifo(2, 8'h30);
    expect_burst(1, 4, 8'h30);
    clear_counts();
    bus.out_ready = 4'b0010;
    bus.req_len = 16'h0040;
    bus.req = 4'b0010;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (s_gnt != '0) bus.req = '0;
      n_vec++;
      if (s_rd_en && s_empty) begin n_err++; $display("FAIL empty_pop: got rd_en=1 with rd_empty=1 expected rd_en=0"); end
    end
    n_vec++;
    if (n_pop != 2 || n_done != 0 || s_busy !== 1'b1) begin
      n_err++;
      $display("FAIL empty_wait: got pops=%0d dones=%0d busy=%b expected 2 0 1", n_pop, n_done, s_busy);
    end
    fill_fifo(2, 8'h32);
    for (int c = 0; c < 50 && n_done < 1; c++) tick();
    n_vec++;
    if (n_done != 1 || n_pop != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL empty_resume: got dones=%0d pops=%0d pending=%0d expected 1 4 0", n_done, n_pop, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic              pat [4];
    logic              was_stalled;
    logic [DATA_W-1:0] held;
    int                n_stall;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    was_stalled = 1'b0;
    held = '0;
    n_stall = 0;
    fill_fifo(4, 8'h50);
    expect_burst(3, 4, 8'h50);
    clear_counts();
    bus.req_len = 16'h4000;
    bus.req = 4'b1000;
    for (int c = 0; c < 60 && n_done < 1; c++) begin
      bus.out_ready = {pat[c % 4], 3'b111};
      tick();
      if (s_gnt != '0) bus.req = '0;
      if (was_stalled && s_valid) begin
        n_vec++;
        if (s_data !== held) begin n_err++; $display("FAIL bp_hold: got data=%0h expected %0h", s_data, held); end
      end
      was_stalled = s_valid && !s_ready_sel;
      if (was_stalled) begin
        n_stall++;
        held = s_data;
        n_vec++;
        if (s_rd_en) begin n_err++; $display("FAIL bp_pop_stalled: got rd_en=1 expected 0"); end
      end
    end
    n_vec++;
    if (n_stall == 0 || n_done != 1 || n_pop != 4 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL bp_summary: got stalls=%0d dones=%0d pops=%0d pending=%0d expected >0 1 4 0",
               n_stall, n_done, n_pop, exp_q.size());
    end
  endtask

  task automatic test_edge_cases();
    clear_counts();
    bus.out_ready = 4'b0110;
    bus.req_len = 16'h0000;
    bus.req = 4'b0100;
    for (int c = 0; c < 8; c++) begin
      tick();
      n_vec++;
      if (s_gnt !== 4'b0000 || s_busy !== 1'b0) begin
        n_err++;
        $display("FAIL len0_ignored: got gnt=%b busy=%b expected 0000 0", s_gnt, s_busy);
      end
    end
    fill_fifo(3, 8'h70);
    expect_burst(1, 3, 8'h70);
    bus.req_len = 16'h0030;
    bus.req = 4'b0110;
    for (int c = 0; c < 20 && grant_log.size() == 0; c++) tick();
    bus.req = 4'b0100;
    bus.req_len = 16'h0010;
    for (int c = 0; c < 50 && n_done < 1; c++) tick();
    repeat (4) tick();
    n_vec++;
    if (grant_log.size() != 1 || grant_log[0] !== 4'b0010) begin
      n_err++;
      $display("FAIL edge_grants: got %0d grants first=%b expected 1 grant 0010",
               grant_log.size(), (grant_log.size() > 0) ? grant_log[0] : 4'b0);
    end
    n_vec++;
    if (n_done != 1 || n_pop != 3 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL edge_burst: got dones=%0d pops=%0d pending=%0d expected 1 3 0", n_done, n_pop, exp_q.size());
    end
    bus.req = '0;
  endtask

  task automatic test_reset_mid_burst();
    fill_fifo(3, 8'h90);
    expect_burst(2, 3, 8'h90);
    clear_counts();
    bus.out_ready = 4'b0100;
    bus.req_len = 16'h0300;
    bus.req = 4'b0100;
    for (int c = 0; c < 20 && grant_log.size() == 0; c++) tick();
    tick();
    rd_rstn = 1'b0;
    #1;
    n_vec++;
    if ({bus.gnt, bus.busy, bus.rd_en, bus.out_valid, bus.out_last, bus.out_data, bus.done} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got gnt=%b busy=%b rd_en=%b valid=%b last=%b data=%0h done=%b, expected all 0",
               bus.gnt, bus.busy, bus.rd_en, bus.out_valid, bus.out_last, bus.out_data, bus.done);
    end
    fifo_q.delete();
    exp_q.delete();
    bus.req = '0;
    prev_gnt = '0;
    update_fifo_pins();
    tick();
    rd_rstn = 1'b1;
    fill_fifo(4, 8'hB0);
    expect_burst(0, 1, 8'hB0);
    clear_counts();
    bus.out_ready = 4'b1111;
    bus.req_len = 16'h1111;
    bus.req = 4'b1111;
    for (int c = 0; c < 50 && n_done < 1; c++) begin
      tick();
      if (grant_log.size() >= 1) bus.req = '0;
    end
    n_vec++;
    if (grant_log.size() < 1 || grant_log[0] !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_priority: got first grant %b expected 0001",
               (grant_log.size() > 0) ? grant_log[0] : 4'b0);
    end
    n_vec++;
    if (n_done != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_recover: got dones=%0d pending=%0d expected 1 0", n_done, exp_q.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    n_pop = 0;
    n_done = 0;
    prev_gnt = '0;
    test_reset();
    test_round_robin();
    test_single_burst();
    test_empty_stall();
    test_backpressure();
    test_edge_cases();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
